// File: rtl/mem_pkg.sv
// Shared types and constants for the memory-stage access controller.
// Holds the top and UART FSM encodings, the UART register map and the status word layout.
package mem_pkg;

  localparam logic [15:0] UART_DATA_DEF = 16'hBF00;
  localparam logic [15:0] UART_STAT_DEF = 16'hBF01;

  localparam int STAT_TX_RDY = 0;
  localparam int STAT_RX_RDY = 1;

  typedef enum logic [2:0] {
    ST_IDLE, ST_SRAM_RD, ST_SRAM_WR, ST_UART, ST_DONE
  } state_e;

  typedef enum logic [2:0] {
    U_IDLE, UART_RD1, UART_RD2, UART_WR, UART_WAIT
  } useq_e;

  function automatic logic [15:0] uart_status(input logic rx_rdy, input logic tx_rdy);
    logic [15:0] s;
    s = '0;
    s[STAT_RX_RDY] = rx_rdy;
    s[STAT_TX_RDY] = tx_rdy;
    return s;
  endfunction

endpackage

// File: rtl/mem_ctrl_uart_seq.sv
// UART read/write strobe sequencer started from the controller's IDLE state.
// Emits a one-cycle uart_done in the last cycle of each access.
module uart_seq import mem_pkg::*; (
  input  logic clk,
  input  logic rst,
  input  logic start_rd,
  input  logic start_wr,
  input  logic uart_tsre,
  output logic uart_rdn,
  output logic uart_wrn,
  output logic bus_drv,
  output logic uart_done,
  output logic rd_done
);

  useq_e st_q, st_d;
  logic  rdn_q, rdn_d, wrn_q, wrn_d, drv_q, drv_d;

  always_comb begin
    st_d = st_q;
    case (st_q)
      U_IDLE:    if (start_wr) st_d = UART_WR;
                 else if (start_rd) st_d = UART_RD1;
      UART_RD1:  st_d = UART_RD2;
      UART_RD2:  st_d = U_IDLE;
      UART_WR:   st_d = UART_WAIT;
      UART_WAIT: if (uart_tsre) st_d = U_IDLE;
      default:   st_d = U_IDLE;
    endcase
    // Strobes are registered from the next state so they change cleanly on the edge.
    rdn_d = !(st_d == UART_RD1 || st_d == UART_RD2);
    wrn_d = !(st_d == UART_WR);
    drv_d = (st_d == UART_WR);
  end

  always_ff @(posedge clk or posedge rst) begin
    if (rst) begin
      st_q  <= U_IDLE;
      rdn_q <= 1'b1;
      wrn_q <= 1'b1;
      drv_q <= 1'b0;
    end else begin
      st_q  <= st_d;
      rdn_q <= rdn_d;
      wrn_q <= wrn_d;
      drv_q <= drv_d;
    end
  end

  assign uart_rdn  = rdn_q;
  assign uart_wrn  = wrn_q;
  assign bus_drv   = drv_q;
  assign rd_done   = (st_q == UART_RD2);
  assign uart_done = (st_q == UART_RD2) || (st_q == UART_WAIT && uart_tsre);

endmodule

// File: rtl/mem_ctrl.sv
// MEM-stage controller: turns load/store requests into SRAM/UART bus cycles
// and stalls the pipeline until each access reaches DONE.
module mem_ctrl import mem_pkg::*; #(
  parameter logic [15:0] UART_DATA_ADDR = UART_DATA_DEF,
  parameter logic [15:0] UART_STAT_ADDR = UART_STAT_DEF
) (
  input  logic        clk,
  input  logic        rst,
  input  logic        mem_read,
  input  logic        mem_write,
  input  logic [15:0] address,
  input  logic [15:0] wdata,
  output logic [15:0] read_data,
  output logic        mem_stall,
  output logic [17:0] ram_addr,
  inout  wire  [15:0] ram_data,
  output logic        ram_en_n,
  output logic        ram_oe_n,
  output logic        ram_we_n,
  output logic        uart_rdn,
  output logic        uart_wrn,
  input  logic        uart_data_ready,
  input  logic        uart_tbre,
  input  logic        uart_tsre
);

  state_e      state_q, state_d;
  logic [15:0] read_data_q, read_data_d;
  logic        ram_en_n_q, ram_en_n_d, ram_oe_n_q, ram_oe_n_d;
  logic        ram_we_n_q, ram_we_n_d, ram_drv_q, ram_drv_d;
  logic        req, is_wr, is_rd, hit_data, hit_stat;
  logic        start_rd, start_wr, uart_done, uart_rd_done, uart_drv;

  // A simultaneous read+write request is handled as a store.
  assign req      = mem_read | mem_write;
  assign is_wr    = mem_write;
  assign is_rd    = mem_read & ~mem_write;
  assign hit_data = (address == UART_DATA_ADDR);
  assign hit_stat = (address == UART_STAT_ADDR);
  assign start_wr = (state_q == ST_IDLE) && is_wr && hit_data;
  assign start_rd = (state_q == ST_IDLE) && is_rd && hit_data;

  uart_seq u_uart_seq (
    .clk       (clk),
    .rst       (rst),
    .start_rd  (start_rd),
    .start_wr  (start_wr),
    .uart_tsre (uart_tsre),
    .uart_rdn  (uart_rdn),
    .uart_wrn  (uart_wrn),
    .bus_drv   (uart_drv),
    .uart_done (uart_done),
    .rd_done   (uart_rd_done)
  );

  always_comb begin
    state_d     = state_q;
    read_data_d = read_data_q;
    case (state_q)
      ST_IDLE: if (req) begin
        if (hit_data) state_d = ST_UART;
        else if (hit_stat) begin
          state_d = ST_DONE;
          if (is_rd) read_data_d = uart_status(uart_data_ready, uart_tbre & uart_tsre);
        end
        else state_d = is_wr ? ST_SRAM_WR : ST_SRAM_RD;
      end
      ST_SRAM_RD: begin
        state_d     = ST_DONE;
        read_data_d = ram_data;
      end
      ST_SRAM_WR: state_d = ST_DONE;
      ST_UART: if (uart_done) begin
        state_d = ST_DONE;
        if (uart_rd_done) read_data_d = {8'h00, ram_data[7:0]};
      end
      ST_DONE: state_d = ST_IDLE;
      default: state_d = ST_IDLE;
    endcase
    ram_en_n_d = !(state_d == ST_SRAM_RD || state_d == ST_SRAM_WR);
    ram_oe_n_d = !(state_d == ST_SRAM_RD);
    ram_we_n_d = !(state_d == ST_SRAM_WR);
    ram_drv_d  = (state_d == ST_SRAM_WR);
  end

  always_ff @(posedge clk or posedge rst) begin
    if (rst) begin
      state_q     <= ST_IDLE;
      read_data_q <= '0;
      ram_en_n_q  <= 1'b1;
      ram_oe_n_q  <= 1'b1;
      ram_we_n_q  <= 1'b1;
      ram_drv_q   <= 1'b0;
    end else begin
      state_q     <= state_d;
      read_data_q <= read_data_d;
      ram_en_n_q  <= ram_en_n_d;
      ram_oe_n_q  <= ram_oe_n_d;
      ram_we_n_q  <= ram_we_n_d;
      ram_drv_q   <= ram_drv_d;
    end
  end

  // Stall drops in DONE so the pipeline advances on that edge; reset also forces it low.
  assign mem_stall = !rst && req && (state_q != ST_DONE);
  assign read_data = read_data_q;
  assign ram_addr  = {2'b00, address};
  assign ram_en_n  = ram_en_n_q;
  assign ram_oe_n  = ram_oe_n_q;
  assign ram_we_n  = ram_we_n_q;
  assign ram_data  = (ram_drv_q | uart_drv) ? wdata : 16'hzzzz;

endmodule

// File: tb/tb_mem_ctrl.sv
// Randomized scoreboard bench for mem_ctrl with an SRAM/UART bus model.
// The shared bus is pulled to 0 when nobody drives it, so store data is kept nonzero.
module tb_mem_ctrl;

  logic        clk = 1'b0, rst = 1'b1;
  logic        mem_read = 1'b0, mem_write = 1'b0;
  logic [15:0] address = 16'h0, wdata = 16'h1;
  logic [15:0] read_data;
  logic        mem_stall;
  logic [17:0] ram_addr;
  tri0  [15:0] ram_data;
  logic        ram_en_n, ram_oe_n, ram_we_n, uart_rdn, uart_wrn;
  logic        uart_data_ready = 1'b0, uart_tbre = 1'b1, uart_tsre = 1'b1;

  typedef struct {
    string       name;
    logic [15:0] rd;
    int          stall, en, oe, we, rdn, wrn, drv;
  } exp_t;

  exp_t        q[$];
  exp_t        me;
  int          checks = 0, errors = 0, done_cnt = 0, cyc = 0;
  int          c_stall, c_en, c_oe, c_we, c_rdn, c_wrn, c_drv, c_bad;
  logic [15:0] dev_mem [0:65535];
  logic [15:0] ref_mem [logic [15:0]];
  logic [15:0] last_rd = 16'h0, uart_rx = 16'h0, tb_bus;
  logic        tb_drv;

  mem_ctrl dut (
    .clk(clk), .rst(rst), .mem_read(mem_read), .mem_write(mem_write),
    .address(address), .wdata(wdata), .read_data(read_data), .mem_stall(mem_stall),
    .ram_addr(ram_addr), .ram_data(ram_data), .ram_en_n(ram_en_n), .ram_oe_n(ram_oe_n),
    .ram_we_n(ram_we_n), .uart_rdn(uart_rdn), .uart_wrn(uart_wrn),
    .uart_data_ready(uart_data_ready), .uart_tbre(uart_tbre), .uart_tsre(uart_tsre)
  );

  always #5 clk = ~clk;
  initial forever begin @(posedge clk); cyc++; end

  // Bus devices: SRAM answers when enabled+output-enabled, UART answers on rdn.
  assign tb_drv   = (!ram_en_n && !ram_oe_n) || !uart_rdn;
  always_comb tb_bus = !uart_rdn ? uart_rx : dev_mem[ram_addr[15:0]];
  assign ram_data = tb_drv ? tb_bus : 16'hzzzz;

  function automatic logic [15:0] init_val(input logic [15:0] a);
    return a ^ 16'hA5C3;
  endfunction

  function automatic logic [15:0] ref_rd(input logic [15:0] a);
    return ref_mem.exists(a) ? ref_mem[a] : init_val(a);
  endfunction

  initial begin
    for (int i = 0; i < 65536; i++) dev_mem[i] = init_val(16'(i));
    forever begin
      @(posedge clk);
      if (!ram_en_n && !ram_we_n) dev_mem[ram_addr[15:0]] = ram_data;
    end
  end

  task automatic chk(input string nm, input logic [31:0] act, input logic [31:0] exp);
    checks++;
    if (act !== exp) begin
      errors++;
      $display("FAIL %s: got %0h expected %0h", nm, act, exp);
    end
  endtask

  task automatic clr_cnt();
    c_stall = 0; c_en = 0; c_oe = 0; c_we = 0; c_rdn = 0; c_wrn = 0; c_drv = 0; c_bad = 0;
  endtask

  // Monitor: accumulates per-access activity and scores it when the stall drops.
  initial begin
    clr_cnt();
    forever begin
      @(negedge clk);
      if (rst) clr_cnt();
      else begin
        if (mem_stall) c_stall++;
        if (!ram_en_n) c_en++;
        if (!ram_oe_n) c_oe++;
        if (!ram_we_n) c_we++;
        if (!uart_rdn) c_rdn++;
        if (!uart_wrn) c_wrn++;
        if (!tb_drv && ram_data != 16'h0) begin
          c_drv++;
          if (ram_data !== wdata) c_bad++;
        end
        if (mem_read || mem_write) begin
          if (!mem_stall) begin
            if (q.size() == 0) chk("unexpected_done", 32'd1, 32'd0);
            else begin
              me = q.pop_front();
              chk({me.name, "_read_data"}, read_data, me.rd);
              chk({me.name, "_stall_cyc"}, c_stall, me.stall);
              chk({me.name, "_en_cyc"},    c_en,    me.en);
              chk({me.name, "_oe_cyc"},    c_oe,    me.oe);
              chk({me.name, "_we_cyc"},    c_we,    me.we);
              chk({me.name, "_rdn_cyc"},   c_rdn,   me.rdn);
              chk({me.name, "_wrn_cyc"},   c_wrn,   me.wrn);
              chk({me.name, "_drv_cyc"},   c_drv,   me.drv);
              chk({me.name, "_drv_val"},   c_bad,   0);
            end
            clr_cnt();
            done_cnt++;
          end
        end else begin
          chk("idle_quiet", {mem_stall, ram_en_n, ram_oe_n, ram_we_n, uart_rdn, uart_wrn},
              6'b011111);
          clr_cnt();
        end
      end
    end
  end

  // kind: 0 sram wr, 1 sram rd, 2 uart wr, 3 uart rd, 4 status rd, 5 status wr, 6 rd+wr
  task automatic issue(input int kind, input logic [15:0] a, input logic [15:0] d,
                       input int k, input logic [15:0] rx, input logic [2:0] st);
    exp_t e;
    int   tgt, n;
    e.name = "sram_wr"; e.rd = 0; e.stall = 0; e.en = 0; e.oe = 0; e.we = 0;
    e.rdn = 0; e.wrn = 0; e.drv = 0;
    if (kind == 2 || kind == 3) a = 16'hBF00;
    if (kind == 4 || kind == 5) a = 16'hBF01;
    tgt = done_cnt + 1;
    address = a; wdata = d; uart_rx = rx; uart_tsre = 1'b1;
    mem_read = 1'b0; mem_write = 1'b0;
    case (kind)
      1: begin mem_read = 1'b1; last_rd = ref_rd(a); e.name = "sram_rd";
               e.stall = 2; e.en = 1; e.oe = 1; end
      2: begin mem_write = 1'b1; uart_tsre = 1'b0; e.name = "uart_wr";
               e.stall = 3 + k; e.wrn = 1; e.drv = 1; end
      3: begin mem_read = 1'b1; last_rd = {8'h00, rx[7:0]}; e.name = "uart_rd";
               e.stall = 3; e.rdn = 2; end
      4: begin mem_read = 1'b1; {uart_data_ready, uart_tbre, uart_tsre} = st;
               last_rd = {14'b0, st[2], st[1] & st[0]}; e.name = "stat_rd"; e.stall = 1; end
      5: begin mem_write = 1'b1; e.name = "stat_wr"; e.stall = 1; end
      default: begin
        mem_write = 1'b1; mem_read = (kind == 6); ref_mem[a] = d;
        if (kind == 6) e.name = "rdwr";
        e.stall = 2; e.en = 1; e.we = 1; e.drv = 1;
      end
    endcase
    e.rd = last_rd;
    q.push_back(e);
    if (kind == 2) begin
      repeat (2 + k) @(posedge clk);
      #1 uart_tsre = 1'b1;
    end
    n = 0;
    while (done_cnt < tgt && n < 64) begin @(negedge clk); #1; n++; end
    if (done_cnt < tgt) begin
      checks++; errors++;
      $display("FAIL %s_timeout: no DONE within %0d cycles", e.name, n);
      q.delete();
      done_cnt = tgt;
    end
    @(posedge clk); #1;
  endtask

  initial begin
    #500000;
    $display("FAIL watchdog: simulation time limit reached");
    $fatal(1, "watchdog");
  end

  initial begin
    int c0, kind;
    // Request held during reset: stall must still be low, strobes idle, bus released.
    mem_read = 1'b1; address = 16'h0040;
    repeat (3) @(posedge clk);
    @(negedge clk);
    chk("rst_read_data", read_data, 16'h0);
    chk("rst_stall", mem_stall, 1'b0);
    chk("rst_strobes", {ram_en_n, ram_oe_n, ram_we_n, uart_rdn, uart_wrn}, 5'b11111);
    chk("rst_bus", ram_data, 16'h0);
    chk("ram_addr_map", ram_addr, 18'h00040);
    @(posedge clk); #1 rst = 1'b0; mem_read = 1'b0;
    @(posedge clk); #1;

    issue(0, 16'h0040, 16'h1234, 0, 0, 3'b0);
    issue(1, 16'h0040, 16'h0001, 0, 0, 3'b0);
    issue(2, 16'hBF00, 16'h0041, 3, 0, 3'b0);
    issue(3, 16'hBF00, 16'h0001, 0, 16'hFF5A, 3'b0);
    issue(4, 16'hBF01, 16'h0001, 0, 0, 3'b110);
    issue(5, 16'hBF01, 16'h0077, 0, 0, 3'b0);
    issue(0, 16'hBEFF, 16'h5AA5, 0, 0, 3'b0);
    issue(1, 16'hBEFF, 16'h0001, 0, 0, 3'b0);
    issue(1, 16'hBF02, 16'h0001, 0, 0, 3'b0);
    issue(6, 16'h0011, 16'hC0DE, 0, 0, 3'b0);
    c0 = cyc;
    issue(1, 16'h0010, 16'h0001, 0, 0, 3'b0);
    issue(1, 16'h0011, 16'h0001, 0, 0, 3'b0);
    chk("b2b_cycles", cyc - c0, 6);

    for (int i = 0; i < 250; i++) begin
      kind = $urandom_range(0, 6);
      issue(kind,
            ($urandom_range(0, 3) == 0) ? 16'($urandom_range(32, 16'hBEFF))
                                        : 16'($urandom_range(0, 31)),
            16'($urandom_range(1, 65535)), $urandom_range(0, 4),
            16'($urandom), 3'($urandom));
      if ($urandom_range(0, 3) == 0) begin
        mem_read = 1'b0; mem_write = 1'b0;
        repeat ($urandom_range(1, 3)) @(posedge clk);
        #1;
      end
    end

    // Reset in the middle of an SRAM store aborts it without touching memory.
    address = 16'h0020; wdata = 16'hBEEF; mem_read = 1'b0; mem_write = 1'b1;
    @(posedge clk); #2;
    chk("abort_we_active", ram_we_n, 1'b0);
    rst = 1'b1; #1;
    chk("abort_we_n", ram_we_n, 1'b1);
    chk("abort_en_n", ram_en_n, 1'b1);
    chk("abort_bus", ram_data, 16'h0);
    chk("abort_stall", mem_stall, 1'b0);
    @(posedge clk); #1 mem_write = 1'b0; rst = 1'b0; last_rd = 16'h0;
    chk("abort_read_data", read_data, 16'h0);
    @(posedge clk); #1;
    issue(1, 16'h0020, 16'h0001, 0, 0, 3'b0);

    mem_read = 1'b0; mem_write = 1'b0;
    repeat (3) @(posedge clk);
    $display("CHECKS %0d ERRORS %0d", checks, errors);
    $finish;
  end

endmodule

// File: doc/mem_ctrl.md
# mem_ctrl

Memory-stage access controller that replaces the behavioural data memory behind the EXE/MEM register. It turns the MEM stage's read/write requests into cycle-accurate strobes on the shared external SRAM/UART data bus. It also raises a stall to the hazard unit so the whole pipeline freezes until each access completes. Load results are returned to the MEM/WB register on the cycle the stall drops.

## Interface
Parameters:
- `UART_DATA_ADDR`, 16'hBF00, memory-mapped UART data register
- `UART_STAT_ADDR`, 16'hBF01, memory-mapped UART status register

Ports:
- `clk`  in  1  pipeline clock
- `rst`  in  1  reset; one clock, reset is asynchronous and active-high
- `mem_read`  in  1  load request from EXE/MEM; held stable while `mem_stall`=1
- `mem_write`  in  1  store request; held stable while `mem_stall`=1
- `address`  in  16  access address (ALU result)
- `wdata`  in  16  store data
- `read_data`  out  16  registered load result, valid in DONE
- `mem_stall`  out  1  freeze request to the hazard unit
- `ram_addr`  out  18  SRAM address = {2'b00, address}
- `ram_data`  inout  16  shared SRAM/UART data bus
- `ram_en_n`, `ram_oe_n`, `ram_we_n`  out  1 each  SRAM strobes, active-low
- `uart_rdn`, `uart_wrn`  out  1 each  UART strobes, active-low
- `uart_data_ready`, `uart_tbre`, `uart_tsre`  in  1 each  UART status

## Operation
- States: IDLE, SRAM_RD, SRAM_WR, UART_RD1, UART_RD2, UART_WR, UART_WAIT, DONE.
- IDLE, request present: the next state depends on the address and request type.
  - UART_DATA_ADDR + read → UART_RD1.
  - UART_DATA_ADDR + write → UART_WR.
  - UART_STAT_ADDR + read → DONE, with `read_data`={14'b0, data_ready, tbre&tsre}.
  - UART_STAT_ADDR + write → DONE, no side effect.
  - Any other address → SRAM_RD or SRAM_WR.
- SRAM_RD: `ram_en_n`=0, `ram_oe_n`=0, bus tri-stated. `ram_data` is captured into `read_data` at the clock edge leaving the state. Next state DONE.
- SRAM_WR: `ram_en_n`=0, bus driven with `wdata`, `ram_we_n`=0 for the full cycle. Next state DONE.
- UART_RD1 → UART_RD2: `uart_rdn`=0 in both states, `ram_en_n`=1. `read_data`={8'h00, ram_data[7:0]} is captured at the edge leaving UART_RD2. Next state DONE.
- UART_WR: bus driven with `wdata`, `uart_wrn`=0 for one cycle. Next state UART_WAIT.
- UART_WAIT: bus released. Stays until `uart_tsre`=1, then DONE. No timeout.
- DONE: all strobes inactive. Unconditionally → IDLE.
- `mem_stall` is combinational and equals (`mem_read`|`mem_write`) && state≠DONE.
- Both `mem_read` and `mem_write` asserted: treated as a write.
- `read_data` holds its last value outside captures. Stores never modify it.
- Bus drive is enabled only in SRAM_WR and UART_WR; the bus is Z in every other state.

## Timing
- Reset values (asynchronous, immediate):
  - state IDLE
  - `read_data`=0, `mem_stall`=0
  - all active-low strobes=1
  - bus Z
- Reset mid-access aborts the access: strobes deassert immediately and no capture occurs.
- Latency per access type (request seen in IDLE):
  - SRAM load/store: 3 cycles total (IDLE, RD/WR, DONE), 2 stall cycles.
  - Status read: 2 cycles, 1 stall cycle.
  - UART read: 4 cycles, 3 stall cycles.
  - UART write: ≥4 cycles, extended by each cycle `tsre`=0.
- The pipeline advances on the DONE edge; MEM/WB samples `read_data` there.
- Back-to-back accesses: the next request appears in IDLE on the cycle after DONE. There is no idle bubble beyond that.
- No request in IDLE: stall=0, all strobes inactive.
- `ram_addr` follows `address` combinationally at all times.

## Structure
- Shared package `mem_pkg`: state encoding enum, UART address constants, status bit positions (bit0 TX ready, bit1 RX ready).
- One natural sub-module: `uart_seq`, which holds the UART_RD1/RD2/WR/WAIT sub-sequence and returns a one-cycle `uart_done` to the top FSM.
- Bus tri-state control stays in `mem_ctrl`.

## Test plan
- SRAM store then load: write 16'h1234 to 16'h0040, then read it back. Expect `ram_we_n` low exactly 1 cycle, `mem_stall` high 2 cycles per access, and `read_data`=16'h1234 in DONE.
- UART write 16'h0041 with `tsre` held low for 3 cycles: `uart_wrn` pulses 1 cycle, stall lasts 6 cycles, `uart_wrn` never re-pulses.
- UART read with bus=16'hFF5A: `uart_rdn` low exactly 2 cycles, `read_data`=16'h005A.
- Status read at 16'hBF01 with data_ready=1, tbre=1, tsre=0: `read_data`=16'h0002 after 1 stall cycle.
- Assert `rst` during SRAM_WR: `ram_we_n`=1 and bus Z in the same cycle, no DONE, `mem_stall`=0.
- Two back-to-back loads from 16'h0010 and 16'h0011: 6 total cycles, correct data in each DONE, bus never driven.
